// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op_code values and controller state encodings.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_BUSY = 2'd2,
        HOLD     = 2'd3
    } mdu_state_e;

    localparam int CNT_W = 2;

endpackage

// File: rtl/mdu_ctrl.sv
// HI/LO owner and sequencer for the external multiplier and divider cores;
// stalls EX while a MULT/DIV is in flight, HOLD covers a completed op still sitting in EX.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        adv,
    input  logic        flush,
    output logic        stallreq,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] mf_result,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    input  logic        div_ready,
    input  logic [63:0] div_result
);

    mdu_state_e       state, state_nxt;
    mdu_op_e          op;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      hi, lo, hi_nxt, lo_nxt;
    logic [31:0]      opa, opb;
    logic             sgn;
    logic             cap_ops;

    assign op   = mdu_op_e'(op_code);
    assign hi_o = hi;
    assign lo_o = lo;

    always_comb begin
        mf_result = '0;
        if (op_valid && op == OP_MFHI) mf_result = hi;
        if (op_valid && op == OP_MFLO) mf_result = lo;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi;
        lo_nxt     = lo;
        cap_ops    = 1'b0;
        stallreq   = 1'b0;
        mul_signed = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_annul  = 1'b0;
        div_opa    = '0;
        div_opb    = '0;

        case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            stallreq   = 1'b1;
                            mul_signed = (op == OP_MULT);
                            mul_a      = src1;
                            mul_b      = src2;
                            cnt_nxt    = CNT_W'(MUL_LAT - 1);
                            cap_ops    = 1'b1;
                            state_nxt  = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            stallreq   = 1'b1;
                            div_start  = 1'b1;
                            div_signed = (op == OP_DIV);
                            div_opa    = src1;
                            div_opb    = src2;
                            cap_ops    = 1'b1;
                            state_nxt  = DIV_BUSY;
                        end
                        OP_MTHI: hi_nxt = src1;
                        OP_MTLO: lo_nxt = src1;
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                // Operands stay on the multiplier until the product has been captured.
                mul_signed = sgn;
                mul_a      = opa;
                mul_b      = opb;
                if (flush) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    stallreq = 1'b1;
                    cnt_nxt  = cnt - 1'b1;
                end else begin
                    hi_nxt    = mul_result[63:32];
                    lo_nxt    = mul_result[31:0];
                    state_nxt = adv ? IDLE : HOLD;
                end
            end
            DIV_BUSY: begin
                div_signed = sgn;
                div_opa    = opa;
                div_opb    = opb;
                if (flush) begin
                    div_annul = 1'b1;
                    state_nxt = IDLE;
                end else if (!div_ready) begin
                    stallreq  = 1'b1;
                    div_start = 1'b1;
                end else begin
                    hi_nxt    = div_result[63:32];
                    lo_nxt    = div_result[31:0];
                    state_nxt = adv ? IDLE : HOLD;
                end
            end
            HOLD: begin
                // The finished instruction is still in EX; wait for it to leave.
                if (adv || flush) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (rst) begin
            stallreq   = 1'b0;
            div_start  = 1'b0;
            div_annul  = 1'b0;
            mul_signed = 1'b0;
            div_opa    = '0;
            div_opb    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opa   <= '0;
            opb   <= '0;
            sgn   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            if (cap_ops) begin
                opa <= src1;
                opb <= src2;
                sgn <= (op == OP_MULT) || (op == OP_DIV);
            end
        end
    end

endmodule
